// File: rtl/fpu_op_scheduler.sv
// Round-robin scheduler sharing one combinational FPU between NUM_REQ requesters.
// Define FPU_SCHED_FLAGS_EN to register {nan, inf, zero, subnormal} result flags.
module fpu_op_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int LAT     = 2,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [2*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [1:0]              fpu_op,
    output logic [31:0]             fpu_a,
    output logic [31:0]             fpu_b,
    input  logic [31:0]             fpu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic [3:0]              rsp_flags,
    output logic                    busy
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    state_e         state_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [CW-1:0]  cnt_q;
    logic [IDW-1:0] grant;
    logic           found;
    logic [1:0]     sel_op;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;

    // Rotating priority search starting at ptr_q
    always_comb begin
        logic [IDW:0] sum;
        grant = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            if (!found && req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                grant = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        ptr_d = grant + IDW'(1);
        if (grant == IDW'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (S_AXI_ARESETN && state_q == IDLE && found) begin
            req_ready = NUM_REQ'(1) << grant;
        end
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            fpu_op    <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        fpu_op  <= sel_op;
                        fpu_a   <= sel_a;
                        fpu_b   <= sel_b;
                        rsp_id  <= grant;
                        ptr_q   <= ptr_d;
                        cnt_q   <= CW'(LAT - 1);
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        rsp_data  <= fpu_result;
                        rsp_valid <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FPU_SCHED_FLAGS_EN
    logic [3:0] flags_d;

    always_comb begin
        logic exp_ones;
        logic exp_zero;
        logic man_zero;
        exp_ones = (fpu_result[30:23] == 8'hFF);
        exp_zero = (fpu_result[30:23] == 8'h00);
        man_zero = (fpu_result[22:0] == 23'd0);
        flags_d  = {exp_ones & ~man_zero, exp_ones & man_zero,
                    exp_zero & man_zero, exp_zero & ~man_zero};
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rsp_flags <= '0;
        end else if (state_q == EXEC && cnt_q == '0) begin
            rsp_flags <= flags_d;
        end
    end
`else
    assign rsp_flags = 4'b0000;
`endif

endmodule
